wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 clk  input  1  clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mem_valid  input  1  MEM stage presents an instruction.
REQ-005 mem_ready  output  1  writeback stage can accept an instruction.
REQ-006 mem_rd  input  5  destination register.
REQ-007 mem_reg_write  input  1  instruction writes rd.
REQ-008 mem_wb_sel  input  2  result source: 0 ALU, 1 LOAD, 2 PC4, 3 reserved.
REQ-009 mem_funct3  input  3  load width/sign code.
REQ-010 mem_alu_result  input  32  ALU result; bits [1:0] give the load byte offset.
REQ-011 mem_pc_plus4  input  32  link value.
REQ-012 dmem_rsp_valid  input  1  load data is valid this cycle.
REQ-013 dmem_rsp_data  input  32  raw aligned memory word.
REQ-014 rf_we  output  1  register-file write enable.
REQ-015 rf_waddr  output  5  register-file write address.
REQ-016 rf_wdata  output  32  register-file write data.
REQ-017 wb_pending  output  1  a load is awaiting data.
REQ-018 wb_pend_rd  output  5  rd of the pending load; 0 when none is pending.
REQ-019 instret  output  64  retired-instruction count (see Configuration).

Function
REQ-020 The FSM SHALL have two states, IDLE and WAIT_LOAD; mem_ready = (state==IDLE).
REQ-021 An instruction SHALL be accepted on mem_valid & mem_ready; all fields are captured on acceptance.
REQ-022 For an accepted non-load, rf_we/rf_waddr/rf_wdata SHALL be valid on the cycle after acceptance (1-cycle latency), and the state SHALL remain IDLE.
REQ-023 For an accepted load (wb_sel=1), the state SHALL go to WAIT_LOAD, with wb_pending=1 and wb_pend_rd=rd.
REQ-024 In WAIT_LOAD, dmem_rsp_valid SHALL produce the write on the following cycle and return the state to IDLE; a new instruction SHALL NOT be accepted in the same cycle as the response.
REQ-025 dmem_rsp_valid SHALL be ignored in IDLE, including the acceptance cycle itself.
REQ-026 Load formatting by funct3: 000 LB sign-extends byte[offset]; 001 LH sign-extends half[offset[1]]; 010 LW; 100 LBU and 101 LHU zero-extend; any other code is treated as LW.
REQ-027 wb_sel=2 SHALL write pc_plus4; wb_sel=3 SHALL write 0.
REQ-028 rf_we = reg_write & (rd != 0); x0 is never written; rf_we SHALL be a single-cycle pulse per instruction.
REQ-029 rf_waddr and rf_wdata SHALL hold their last values when rf_we=0.
REQ-030 Each accepted instruction SHALL complete exactly once, in order; at most one is in flight.

Reset
REQ-031 On reset: state=IDLE; rf_we=0, rf_waddr=0, rf_wdata=0, wb_pending=0, wb_pend_rd=0, instret=0; mem_ready=1 from the first cycle after reset.
REQ-032 Reset asserted during WAIT_LOAD SHALL abandon the load without a write; a late response arriving after reset is ignored per REQ-025.

Configuration
REQ-033 Macro WB_INSTRET_EN: when defined, instret SHALL increment by 1 on each completion (the cycle rf_we would pulse, including reg_write=0 and rd=0 cases) and wrap modulo 2^64.
REQ-034 When WB_INSTRET_EN is undefined, instret SHALL be tied to 0 and no counter logic is synthesised.

Structure
REQ-035 Package wb_pkg SHALL hold the wb_sel enum, the load funct3 constants, and the FSM state enum.
REQ-036 Load formatting SHALL live in a combinational sub-module, load_align (inputs: data, offset, funct3; output: 32-bit result).

Verification
REQ-037 ALU op rd=5, alu_result=0x1234_5678, reg_write=1 -> next cycle rf_we=1, waddr=5, wdata=0x1234_5678.
REQ-038 LB rd=3, offset=3, rsp data 0x80FF_FFFF two cycles later -> mem_ready=0 while pending, wb_pend_rd=3; one cycle after rsp, wdata=0xFFFF_FF80; then IDLE.
REQ-039 LHU offset=2, data 0xBEEF_0000 -> wdata=0x0000_BEEF; LH with the same data -> 0xFFFF_BEEF.
REQ-040 JAL rd=0, pc_plus4=0x104 -> rf_we stays 0; with WB_INSTRET_EN defined, instret increments by 1.
REQ-041 Reset during WAIT_LOAD, then rsp_valid on the next cycle -> no rf_we pulse, wb_pending=0, instret=0.
REQ-042 Back-to-back ALU ops for three cycles -> three consecutive rf_we pulses with matching addresses and data; instret=3 when WB_INSTRET_EN is defined.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: result-source select, load funct3 codes
// and the two-state writeback FSM encoding.
package wb_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_PC4  = 2'd2,
      WB_RSVD = 2'd3
   } wb_sel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_LOAD = 1'b1
   } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: picks the byte/half addressed by the offset
// and sign- or zero-extends it according to funct3; unknown codes act as LW.
module load_align
   import wb_pkg::*;
(
   input  logic [31:0] data,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = data[7:0];
      case (offset)
         2'd1:    byte_sel = data[15:8];
         2'd2:    byte_sel = data[23:16];
         2'd3:    byte_sel = data[31:24];
         default: byte_sel = data[7:0];
      endcase
      // Halfword loads only look at offset[1]; offset[0] is ignored.
      half_sel = offset[1] ? data[31:16] : data[15:0];
   end

   always_comb begin
      result = data;
      case (funct3)
         F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   result = {{16{half_sel[15]}}, half_sel};
         F3_LBU:  result = {24'd0, byte_sel};
         F3_LHU:  result = {16'd0, half_sel};
         default: result = data;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Pipeline writeback stage: accepts one instruction at a time from MEM, writes
// ALU/PC+4 results a cycle later and parks loads until the memory response.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module wb_stage
   import wb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            mem_valid,
   output logic            mem_ready,
   input  logic [4:0]      mem_rd,
   input  logic            mem_reg_write,
   input  logic [1:0]      mem_wb_sel,
   input  logic [2:0]      mem_funct3,
   input  logic [XLEN-1:0] mem_alu_result,
   input  logic [XLEN-1:0] mem_pc_plus4,
   input  logic            dmem_rsp_valid,
   input  logic [XLEN-1:0] dmem_rsp_data,
   output logic            rf_we,
   output logic [4:0]      rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic            wb_pending,
   output logic [4:0]      wb_pend_rd,
   output logic [63:0]     instret
);

   wb_state_e   state;
   wb_state_e   next_state;
   logic        accept;
   logic        load_done;
   logic        is_load;
   logic [4:0]  pend_rd;
   logic        pend_reg_write;
   logic [2:0]  pend_funct3;
   logic [1:0]  pend_offset;
   logic [XLEN-1:0] direct_wdata;
   logic [31:0] load_data;

   assign is_load = (wb_sel_e'(mem_wb_sel) == WB_LOAD);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Responses are only consumed in WAIT_LOAD, and that cycle never accepts.
   always_comb begin
      next_state = state;
      mem_ready  = 1'b0;
      accept     = 1'b0;
      load_done  = 1'b0;
      case (state)
         IDLE: begin
            mem_ready = 1'b1;
            if (mem_valid) begin
               accept = 1'b1;
               if (is_load) begin
                  next_state = WAIT_LOAD;
               end
            end
         end
         WAIT_LOAD: begin
            if (dmem_rsp_valid) begin
               load_done  = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      direct_wdata = '0;
      case (wb_sel_e'(mem_wb_sel))
         WB_ALU:  direct_wdata = mem_alu_result;
         WB_PC4:  direct_wdata = mem_pc_plus4;
         default: direct_wdata = '0;
      endcase
   end

   load_align u_load_align (
      .data   (dmem_rsp_data),
      .offset (pend_offset),
      .funct3 (pend_funct3),
      .result (load_data)
   );

   // Write port registers: rf_we pulses once, address/data hold between writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_we          <= 1'b0;
         rf_waddr       <= '0;
         rf_wdata       <= '0;
         pend_rd        <= '0;
         pend_reg_write <= 1'b0;
         pend_funct3    <= '0;
         pend_offset    <= '0;
      end else begin
         rf_we <= 1'b0;
         if (accept) begin
            if (is_load) begin
               pend_rd        <= mem_rd;
               pend_reg_write <= mem_reg_write;
               pend_funct3    <= mem_funct3;
               pend_offset    <= mem_alu_result[1:0];
            end else if (mem_reg_write && (mem_rd != 5'd0)) begin
               rf_we    <= 1'b1;
               rf_waddr <= mem_rd;
               rf_wdata <= direct_wdata;
            end
         end else if (load_done && pend_reg_write && (pend_rd != 5'd0)) begin
            rf_we    <= 1'b1;
            rf_waddr <= pend_rd;
            rf_wdata <= load_data;
         end
      end
   end

   assign wb_pending = (state == WAIT_LOAD);
   assign wb_pend_rd = wb_pending ? pend_rd : 5'd0;

`ifdef WB_INSTRET_EN
   logic complete;

   // Completions count even when the write itself is suppressed (rd=0 etc.).
   assign complete = (accept && !is_load) || load_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         instret <= '0;
      end else if (complete) begin
         instret <= instret + 64'd1;
      end
   end
`else
   assign instret = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Randomized scoreboard bench for wb_stage: the driver pushes expected register
// writes (with the cycle they must appear) and a negedge monitor checks them.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_rd;
   logic        mem_reg_write;
   logic [1:0]  mem_wb_sel;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_alu_result;
   logic [31:0] mem_pc_plus4;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rsp_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        wb_pending;
   logic [4:0]  wb_pend_rd;
   logic [63:0] instret;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      longint      cyc;
   } exp_t;

   exp_t              sb[$];
   int                tests = 0;
   int                fails = 0;
   longint            cyc = 0;
   longint unsigned   model_instret = 0;
   logic [4:0]        last_addr = '0;
   logic [31:0]       last_data = '0;

   wb_stage #(.XLEN(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .mem_valid      (mem_valid),
      .mem_ready      (mem_ready),
      .mem_rd         (mem_rd),
      .mem_reg_write  (mem_reg_write),
      .mem_wb_sel     (mem_wb_sel),
      .mem_funct3     (mem_funct3),
      .mem_alu_result (mem_alu_result),
      .mem_pc_plus4   (mem_pc_plus4),
      .dmem_rsp_valid (dmem_rsp_valid),
      .dmem_rsp_data  (dmem_rsp_data),
      .rf_we          (rf_we),
      .rf_waddr       (rf_waddr),
      .rf_wdata       (rf_wdata),
      .wb_pending     (wb_pending),
      .wb_pend_rd     (wb_pend_rd),
      .instret        (instret)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference load semantics expressed as shifts and masks on the raw word.
   function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] off,
                                            input logic [2:0] f3);
      logic [31:0] b;
      logic [31:0] h;
      b = (word >> (8 * off)) & 32'hFF;
      h = (word >> (16 * (off / 2))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
         3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return word;
      endcase
   endfunction

   function automatic logic [63:0] exp_instret();
`ifdef WB_INSTRET_EN
      return model_instret;
`else
      return 64'd0;
`endif
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         last_addr = '0;
         last_data = '0;
      end else if (rf_we) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_write", {27'd0, rf_waddr}, 64'h1_0000_0000);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("write_addr", {59'd0, rf_waddr}, {59'd0, e.addr});
            checkOutput("write_data", {32'd0, rf_wdata}, {32'd0, e.data});
            checkOutput("write_cycle", cyc, e.cyc);
            last_addr = e.addr;
            last_data = e.data;
         end
      end else begin
         checkOutput("hold_addr", {59'd0, rf_waddr}, {59'd0, last_addr});
         checkOutput("hold_data", {32'd0, rf_wdata}, {32'd0, last_data});
      end
   end

   // Issues one instruction; for loads also waits `delay` cycles then responds.
   task automatic applyStimulus(input logic [1:0] sel, input logic [2:0] f3, input logic [4:0] rd,
                                input logic rw, input logic [31:0] alu, input logic [31:0] pc4,
                                input logic [31:0] rsp, input int delay, input logic noise);
      longint k;
      mem_valid      = 1'b1;
      mem_wb_sel     = sel;
      mem_funct3     = f3;
      mem_rd         = rd;
      mem_reg_write  = rw;
      mem_alu_result = alu;
      mem_pc_plus4   = pc4;
      dmem_rsp_valid = noise;
      dmem_rsp_data  = $urandom;
      k = cyc;
      @(posedge clk); #1;
      mem_valid      = 1'b0;
      dmem_rsp_valid = 1'b0;
      if (sel != 2'd1) begin
         if (rw && rd != 5'd0)
            sb.push_back('{addr: rd, data: (sel == 2'd0) ? alu : (sel == 2'd2) ? pc4 : 32'd0,
                           cyc: k + 1});
         model_instret++;
      end else begin
         checkOutput("ready_low", {63'd0, mem_ready}, 64'd0);
         checkOutput("pending_set", {63'd0, wb_pending}, 64'd1);
         checkOutput("pend_rd", {59'd0, wb_pend_rd}, {59'd0, rd});
         for (int d = 0; d < delay; d++) begin
            if (noise) begin
               mem_valid     = 1'b1;
               mem_wb_sel    = 2'd0;
               mem_reg_write = 1'b1;
               mem_rd        = 5'd1 + 5'($urandom_range(0, 30));
            end
            @(posedge clk); #1;
            mem_valid = 1'b0;
         end
         mem_valid      = noise;
         mem_wb_sel     = 2'd0;
         mem_reg_write  = 1'b1;
         mem_rd         = 5'd9;
         dmem_rsp_valid = 1'b1;
         dmem_rsp_data  = rsp;
         k = cyc;
         if (rw && rd != 5'd0)
            sb.push_back('{addr: rd, data: ref_load(rsp, alu[1:0], f3), cyc: k + 1});
         model_instret++;
         @(posedge clk); #1;
         dmem_rsp_valid = 1'b0;
         mem_valid      = 1'b0;
         checkOutput("ready_after_load", {63'd0, mem_ready}, 64'd1);
         checkOutput("pending_clear", {63'd0, wb_pending}, 64'd0);
      end
   endtask

   task automatic doReset();
      reset = 1'b1;
      mem_valid = 1'b0;
      dmem_rsp_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      model_instret = 0;
   endtask

   initial begin
      reset = 1'b1;
      mem_valid = 1'b0; mem_rd = '0; mem_reg_write = 1'b0; mem_wb_sel = '0; mem_funct3 = '0;
      mem_alu_result = '0; mem_pc_plus4 = '0; dmem_rsp_valid = 1'b0; dmem_rsp_data = '0;
      doReset();
      checkOutput("rst_rf_we", {63'd0, rf_we}, 64'd0);
      checkOutput("rst_waddr", {59'd0, rf_waddr}, 64'd0);
      checkOutput("rst_wdata", {32'd0, rf_wdata}, 64'd0);
      checkOutput("rst_pending", {63'd0, wb_pending}, 64'd0);
      checkOutput("rst_pend_rd", {59'd0, wb_pend_rd}, 64'd0);
      checkOutput("rst_instret", instret, 64'd0);
      checkOutput("rst_ready", {63'd0, mem_ready}, 64'd1);

      applyStimulus(2'd0, 3'd0, 5'd5, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 0, 1'b0);
      checkOutput("alu_vec_we", {63'd0, rf_we}, 64'd1);
      checkOutput("alu_vec_data", {32'd0, rf_wdata}, 64'h1234_5678);

      applyStimulus(2'd1, 3'd0, 5'd3, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 1, 1'b0);
      checkOutput("lb_vec_data", {32'd0, rf_wdata}, 64'hFFFF_FF80);
      applyStimulus(2'd1, 3'd5, 5'd4, 1'b1, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 0, 1'b1);
      checkOutput("lhu_vec_data", {32'd0, rf_wdata}, 64'h0000_BEEF);
      applyStimulus(2'd1, 3'd1, 5'd6, 1'b1, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 2, 1'b1);
      checkOutput("lh_vec_data", {32'd0, rf_wdata}, 64'hFFFF_BEEF);

      applyStimulus(2'd2, 3'd0, 5'd0, 1'b1, 32'h0, 32'h0000_0104, 32'h0, 0, 1'b0);
      checkOutput("jal_x0_we", {63'd0, rf_we}, 64'd0);
      checkOutput("jal_instret", instret, exp_instret());

      applyStimulus(2'd1, 3'd2, 5'd7, 1'b1, 32'h0, 32'h0, 32'h0, 0, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      sb.delete();
      model_instret = 0;
      dmem_rsp_valid = 1'b1;
      dmem_rsp_data  = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      dmem_rsp_valid = 1'b0;
      checkOutput("abandon_we", {63'd0, rf_we}, 64'd0);
      checkOutput("abandon_pending", {63'd0, wb_pending}, 64'd0);
      checkOutput("abandon_pend_rd", {59'd0, wb_pend_rd}, 64'd0);
      checkOutput("abandon_instret", instret, 64'd0);
      checkOutput("abandon_ready", {63'd0, mem_ready}, 64'd1);

      doReset();
      for (int i = 0; i < 3; i++)
         applyStimulus(2'd0, 3'd0, 5'(10 + i), 1'b1, 32'hA000_0000 + i, 32'h0, 32'h0, 0, 1'b0);
      checkOutput("b2b_instret", instret, exp_instret());

      for (int i = 0; i < 300; i++) begin
         applyStimulus(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                       ($urandom_range(0, 7) != 0), $urandom, $urandom, $urandom,
                       $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end
      repeat (2) @(posedge clk);
      #1;
      checkOutput("sb_drained", 64'(sb.size()), 64'd0);
      checkOutput("final_instret", instret, exp_instret());

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
